time_of_day_counter: RTL and testbench

Upstream timekeeping stage that feeds the calendar block. It divides clk_100MHz down to a 1 s time base and keeps hours, minutes and seconds in binary. It accepts hour and minute set buttons. It drives tick_1Hz and end_of_day, which the calendar uses to advance its date.

---
 rtl/time_of_day_counter.sv | 117 +++++++++++
 tb/tb_time_of_day_counter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: 1 s prescaler plus binary h:m:s with set buttons; CLOCK_12H_EN adds hour_12/pm outputs
module time_of_day_counter #(
  parameter int CLK_FREQ_HZ    = 100000000,
  parameter int DEFAULT_HOUR   = 0,
  parameter int DEFAULT_MINUTE = 0,
  parameter int DEFAULT_SECOND = 0
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       inc_hour,
  input  logic       inc_minute,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic       sec_pulse,
  output logic       tick_1Hz,
  output logic       end_of_day
`ifdef CLOCK_12H_EN
  ,
  output logic [7:0] hour_12,
  output logic       pm
`endif
);
  localparam int DIV = CLK_FREQ_HZ;
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(DIV / 2);
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0] hour_q, hour_d, minute_q, minute_d, second_q, second_d;
  logic sec_pulse_q, sec_pulse_d, tick_q, tick_d, eod_q, eod_d;
  logic [1:0] sync_h_q, sync_h_d, sync_m_q, sync_m_d;
  logic prev_h_q, prev_h_d, prev_m_q, prev_m_d;
  logic wrap, ev_h, ev_m, manual, s_wrap, m_wrap, h_wrap;
  logic [7:0] hour_inc, minute_inc, second_inc;
  // next state: manual set events take priority over the once-per-second natural carry
  always_comb begin
    wrap        = presc_q == LAST;
    ev_h        = sync_h_q[1] & ~prev_h_q;
    ev_m        = sync_m_q[1] & ~prev_m_q;
    manual      = ev_h | ev_m;
    s_wrap      = second_q >= 8'd59;
    m_wrap      = minute_q >= 8'd59;
    h_wrap      = hour_q >= 8'd23;
    hour_inc    = h_wrap ? 8'd0 : hour_q + 8'd1;
    minute_inc  = m_wrap ? 8'd0 : minute_q + 8'd1;
    second_inc  = s_wrap ? 8'd0 : second_q + 8'd1;
    presc_d     = wrap ? '0 : presc_q + 1'b1;
    sec_pulse_d = wrap;
    tick_d      = presc_d >= HALF;
    second_d    = ev_m ? 8'd0 : (!manual && wrap ? second_inc : second_q);
    minute_d    = ev_m ? minute_inc : (!manual && wrap && s_wrap ? minute_inc : minute_q);
    hour_d      = ev_h ? hour_inc : (!manual && wrap && s_wrap && m_wrap ? hour_inc : hour_q);
    eod_d       = wrap ? (!manual && hour_q == 8'd23 && minute_q == 8'd59 && second_q == 8'd59) : eod_q;
    sync_h_d    = {sync_h_q[0], inc_hour};
    sync_m_d    = {sync_m_q[0], inc_minute};
    prev_h_d    = sync_h_q[1];
    prev_m_d    = sync_m_q[1];
  end
  // state registers with synchronous active-low reset to the default time
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      presc_q     <= '0;
      hour_q      <= 8'(DEFAULT_HOUR);
      minute_q    <= 8'(DEFAULT_MINUTE);
      second_q    <= 8'(DEFAULT_SECOND);
      sec_pulse_q <= 1'b0;
      tick_q      <= 1'b0;
      eod_q       <= 1'b0;
      sync_h_q    <= '0;
      sync_m_q    <= '0;
      prev_h_q    <= 1'b0;
      prev_m_q    <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      hour_q      <= hour_d;
      minute_q    <= minute_d;
      second_q    <= second_d;
      sec_pulse_q <= sec_pulse_d;
      tick_q      <= tick_d;
      eod_q       <= eod_d;
      sync_h_q    <= sync_h_d;
      sync_m_q    <= sync_m_d;
      prev_h_q    <= prev_h_d;
      prev_m_q    <= prev_m_d;
    end
  end
  assign hour       = hour_q;
  assign minute     = minute_q;
  assign second     = second_q;
  assign sec_pulse  = sec_pulse_q;
  assign tick_1Hz   = tick_q;
  assign end_of_day = eod_q;
`ifdef CLOCK_12H_EN
  logic [7:0] hour_12_q, hour_12_d;
  logic pm_q, pm_d;
  function automatic logic [7:0] to_12(input logic [7:0] h);
    return h == 8'd0 ? 8'd12 : (h > 8'd12 ? h - 8'd12 : h);
  endfunction
  // 12-hour view derived from the same next-hour value so it moves with hour
  always_comb begin
    hour_12_d = to_12(hour_d);
    pm_d      = hour_d >= 8'd12;
  end
  // 12-hour registers, reset from the default hour
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      hour_12_q <= to_12(8'(DEFAULT_HOUR));
      pm_q      <= 8'(DEFAULT_HOUR) >= 8'd12;
    end else begin
      hour_12_q <= hour_12_d;
      pm_q      <= pm_d;
    end
  end
  assign hour_12 = hour_12_q;
  assign pm      = pm_q;
`endif
endmodule

// File: tb/tb_time_of_day_counter.sv
// tb_time_of_day_counter: directed checks of prescaler, carry chain, set buttons and reset
module tb_time_of_day_counter;
  localparam int DIV = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic inc_hour = 1'b0;
  logic inc_minute = 1'b0;
  logic [7:0] hour, minute, second;
  logic sec_pulse, tick_1Hz, end_of_day;
`ifdef CLOCK_12H_EN
  logic [7:0] hour_12;
  logic pm;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_of_day_counter #(.CLK_FREQ_HZ(DIV)) dut (
    .clk_100MHz(clk), .reset(reset), .inc_hour(inc_hour), .inc_minute(inc_minute),
    .hour(hour), .minute(minute), .second(second), .sec_pulse(sec_pulse),
    .tick_1Hz(tick_1Hz), .end_of_day(end_of_day)
`ifdef CLOCK_12H_EN
    , .hour_12(hour_12), .pm(pm)
`endif
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3 * DIV && !got; i++) begin
      @(negedge clk);
      got = sec_pulse;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wait_pulse: sec_pulse stayed 0, required 1 within %0d cycles", 3 * DIV);
    end
  endtask

  task automatic press(input bit h, input bit m);
    inc_hour = 1'b0;
    inc_minute = 1'b0;
    cyc(3);
    inc_hour = h;
    inc_minute = m;
    cyc(3);
    inc_hour = 1'b0;
    inc_minute = 1'b0;
  endtask

  // returns at the negedge of the sec_pulse cycle that brought second to s
  task automatic set_time(input int h, input int m, input int s);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    repeat (h) press(1'b1, 1'b0);
    repeat (m == 0 ? 60 : m) press(1'b0, 1'b1);
    repeat (s) wait_pulse();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(3);
    checks++;
    if ({hour, minute, second, sec_pulse, tick_1Hz, end_of_day} !== 27'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d:%0d:%0d sp=%b tick=%b eod=%b, required 0:0:0 0 0 0",
               hour, minute, second, sec_pulse, tick_1Hz, end_of_day);
    end
`ifdef CLOCK_12H_EN
    checks++;
    if ({hour_12, pm} !== {8'd12, 1'b0}) begin
      errors++;
      $display("FAIL reset_12h: got %0d pm=%b, required 12 pm=0", hour_12, pm);
    end
`endif
    reset = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      checks++;
      if (sec_pulse !== (k % DIV == 0)) begin
        errors++;
        $display("FAIL prescaler_pulse cycle %0d: got %b, required %b", k, sec_pulse, k % DIV == 0);
      end
      checks++;
      if (tick_1Hz !== (k % DIV >= DIV / 2)) begin
        errors++;
        $display("FAIL tick_phase cycle %0d: got %b, required %b", k, tick_1Hz, k % DIV >= DIV / 2);
      end
    end
    checks++;
    if ({hour, minute, second} !== {8'd0, 8'd0, 8'd3}) begin
      errors++;
      $display("FAIL three_seconds: got %0d:%0d:%0d, required 0:0:3", hour, minute, second);
    end
  endtask

  task automatic test_end_of_day();
    int hi, rises;
    logic prev;
    set_time(23, 59, 58);
    checks++;
    if ({hour, minute, second, end_of_day} !== {8'd23, 8'd59, 8'd58, 1'b0}) begin
      errors++;
      $display("FAIL setup_235958: got %0d:%0d:%0d eod=%b, required 23:59:58 eod=0", hour, minute, second, end_of_day);
    end
    wait_pulse();
    wait_pulse();
    checks++;
    if ({hour, minute, second, end_of_day} !== {8'd0, 8'd0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL day_rollover: got %0d:%0d:%0d eod=%b, required 0:0:0 eod=1", hour, minute, second, end_of_day);
    end
    hi = 1;
    rises = 0;
    prev = tick_1Hz;
    for (int i = 1; i <= DIV; i++) begin
      @(negedge clk);
      if (end_of_day) begin
        hi++;
        if (tick_1Hz && !prev) rises++;
      end
      prev = tick_1Hz;
    end
    checks++;
    if (hi !== DIV) begin
      errors++;
      $display("FAIL eod_width: got %0d cycles, required %0d", hi, DIV);
    end
    checks++;
    if (rises !== 1) begin
      errors++;
      $display("FAIL eod_tick_edges: got %0d, required 1", rises);
    end
  endtask

  task automatic test_inc_minute();
    set_time(10, 59, 30);
    checks++;
    if ({hour, minute, second} !== {8'd10, 8'd59, 8'd30}) begin
      errors++;
      $display("FAIL setup_105930: got %0d:%0d:%0d, required 10:59:30", hour, minute, second);
    end
    inc_minute = 1'b1;
    cyc(3);
    checks++;
    if ({hour, minute, second, end_of_day} !== {8'd10, 8'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL minute_wrap: got %0d:%0d:%0d eod=%b, required 10:0:0 eod=0", hour, minute, second, end_of_day);
    end
    cyc(50);
    inc_minute = 1'b0;
    cyc(3);
    checks++;
    if ({hour, minute} !== {8'd10, 8'd0}) begin
      errors++;
      $display("FAIL minute_hold: got %0d:%0d, required 10:0", hour, minute);
    end
  endtask

  task automatic test_inc_hour();
    set_time(23, 15, 7);
    press(1'b1, 1'b0);
    checks++;
    if ({hour, minute, second, end_of_day} !== {8'd0, 8'd15, 8'd7, 1'b0}) begin
      errors++;
      $display("FAIL hour_wrap: got %0d:%0d:%0d eod=%b, required 0:15:7 eod=0", hour, minute, second, end_of_day);
    end
    set_time(5, 20, 40);
    press(1'b1, 1'b1);
    checks++;
    if ({hour, minute, second} !== {8'd6, 8'd21, 8'd0}) begin
      errors++;
      $display("FAIL both_buttons: got %0d:%0d:%0d, required 6:21:0", hour, minute, second);
    end
  endtask

  task automatic test_collision();
    set_time(12, 34, 59);
    cyc(5);
    inc_minute = 1'b1;
    cyc(3);
    checks++;
    if (sec_pulse !== 1'b1) begin
      errors++;
      $display("FAIL collision_pulse: got %b, required 1", sec_pulse);
    end
    checks++;
    if ({hour, minute, second, end_of_day} !== {8'd12, 8'd35, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL collision_time: got %0d:%0d:%0d eod=%b, required 12:35:0 eod=0", hour, minute, second, end_of_day);
    end
    inc_minute = 1'b0;
  endtask

  task automatic test_reset_mid();
    int first;
    set_time(7, 7, 7);
    cyc(5);
    reset = 1'b0;
    cyc(1);
    checks++;
    if ({hour, minute, second, sec_pulse, tick_1Hz, end_of_day} !== 27'd0) begin
      errors++;
      $display("FAIL mid_reset: got %0d:%0d:%0d sp=%b tick=%b eod=%b, required 0:0:0 0 0 0",
               hour, minute, second, sec_pulse, tick_1Hz, end_of_day);
    end
    reset = 1'b1;
    first = 0;
    for (int k = 1; k <= DIV; k++) begin
      @(negedge clk);
      if (sec_pulse && first == 0) first = k;
    end
    checks++;
    if (first !== DIV) begin
      errors++;
      $display("FAIL prescaler_restart: first pulse at %0d, required %0d", first, DIV);
    end
`ifdef CLOCK_12H_EN
    checks++;
    if ({hour_12, pm} !== {8'd12, 1'b0}) begin
      errors++;
      $display("FAIL h12_midnight: got %0d pm=%b, required 12 pm=0", hour_12, pm);
    end
    repeat (13) press(1'b1, 1'b0);
    checks++;
    if ({hour, hour_12, pm} !== {8'd13, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL h12_13: got hour=%0d h12=%0d pm=%b, required 13 1 1", hour, hour_12, pm);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_end_of_day();
    test_inc_minute();
    test_inc_hour();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
